// File: rtl/testbasic8_source_pkg.sv
// testbasic8_types: shared state encoding and priming token for the TestBasic8 source
package testbasic8_types;
  typedef enum logic [1:0] {PRIME, IDLE, SEND} src_state_t;
  localparam logic [31:0] SRC_INIT_VALUE = 32'd1337;
endpackage

// File: rtl/testbasic8_src_fifo.sv
// testbasic8_src_fifo: synchronous FIFO with wrap-bit pointers and a combinational head
module testbasic8_src_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign head = mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + (AW+1)'(1);
      end
      if (pop) rd <= rd + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/testbasic8_source.sv
// testbasic8_source: primes with INIT_VALUE, then forwards buffered samples over a blocking handshake
module testbasic8_source
  import testbasic8_types::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] INIT_VALUE = SRC_INIT_VALUE,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       m_in,
  input  logic              m_in_sync,
  output logic [31:0]       b_out,
  output logic              b_out_notify,
  input  logic              b_out_sync,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy
);
  src_state_t state, nxt;
  logic xfer, idle, pop, bypass, load, push, drop, full, empty;
  logic [31:0] head;
  testbasic8_src_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(m_in),
    .head(head), .full(full), .empty(empty)
  );
  // IDLE also drains a sample pushed on the same edge the FIFO ran dry
  always_comb begin
    xfer = b_out_notify && b_out_sync;
    idle = state == IDLE;
    pop = (xfer || idle) && !empty;
    bypass = idle && empty && m_in_sync;
    load = pop || bypass;
    push = m_in_sync && !bypass && (!full || pop);
    drop = m_in_sync && !bypass && full && !pop;
    nxt = load ? SEND : (xfer || idle) ? IDLE : state;
  end
  assign busy = !idle || !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIME;
      b_out <= INIT_VALUE;
      b_out_notify <= 1'b1;
      drop_count <= '0;
    end else begin
      state <= nxt;
      b_out_notify <= nxt != IDLE;
      if (load) b_out <= bypass ? m_in : head;
      if (drop && !(&drop_count)) drop_count <= drop_count + DROP_W'(1);
    end
  end
endmodule

// File: tb/tb_testbasic8_source.sv
// tb_testbasic8_source: scoreboard bench; expected deliveries queued at drive time, popped per transfer
module tb_testbasic8_source;
  localparam logic [31:0] INIT = 32'd1337;
  logic clk = 0, rst = 1;
  logic [31:0] m_in = 0;
  logic m_in_sync = 0, b_out_sync = 0;
  logic [31:0] b_out, b_out2;
  logic b_out_notify, b_out_notify2, busy, busy2;
  logic [15:0] drop_count;
  logic [1:0] drop_count2;
  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  testbasic8_source #(.DEPTH(4), .INIT_VALUE(INIT), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .m_in(m_in), .m_in_sync(m_in_sync), .b_out(b_out),
    .b_out_notify(b_out_notify), .b_out_sync(b_out_sync), .drop_count(drop_count), .busy(busy)
  );
  testbasic8_source #(.DEPTH(4), .INIT_VALUE(INIT), .DROP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .m_in(m_in), .m_in_sync(m_in_sync), .b_out(b_out2),
    .b_out_notify(b_out_notify2), .b_out_sync(b_out_sync), .drop_count(drop_count2), .busy(busy2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // a transfer happens on the next posedge whenever notify and sync are both high here
  always @(negedge clk) begin
    if (!rst && b_out_notify && b_out_sync) begin
      chk("xfer_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("xfer_data", b_out, exp_q[0]);
        chk("xfer_data_sat", b_out2, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    exp_q.delete();
    step();
    rst = 0;
    exp_q.push_back(INIT);
  endtask
  task automatic push(input logic [31:0] v, input bit accepted);
    m_in = v;
    m_in_sync = 1;
    if (accepted) exp_q.push_back(v);
    step();
    m_in_sync = 0;
  endtask
  task automatic drain_and_idle(input string tag);
    b_out_sync = 1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    chk({tag, "_drained"}, 32'(exp_q.size()), 0);
    step();
    step();
    chk({tag, "_idle_notify"}, 32'(b_out_notify), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
  endtask
  initial begin
    // reset with reader ready: priming token, then idle
    b_out_sync = 1;
    do_reset();
    chk("rst_b_out", b_out, INIT);
    chk("rst_notify", 32'(b_out_notify), 1);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_drop", 32'(drop_count), 0);
    step();
    chk("t1_notify", 32'(b_out_notify), 0);
    chk("t1_busy", 32'(busy), 0);
    // reader stalled while two samples arrive behind the token
    b_out_sync = 0;
    do_reset();
    push(5, 1);
    push(6, 1);
    step();
    chk("t2_hold", b_out, INIT);
    chk("t2_hold_notify", 32'(b_out_notify), 1);
    drain_and_idle("t2");
    // bypass latency from IDLE
    b_out_sync = 0;
    push(42, 1);
    chk("t3_notify", 32'(b_out_notify), 1);
    chk("t3_b_out", b_out, 42);
    drain_and_idle("t3");
    // overflow: 1 in output reg, 2..5 buffered, 6 dropped
    b_out_sync = 0;
    for (int v = 1; v <= 6; v++) push(32'(v), v != 6);
    chk("t4_b_out", b_out, 1);
    chk("t4_drop", 32'(drop_count), 1);
    drain_and_idle("t4");
    // full FIFO with simultaneous pop and push keeps the sample
    b_out_sync = 0;
    for (int v = 10; v <= 14; v++) push(32'(v), 1);
    b_out_sync = 1;
    push(15, 1);
    chk("t5_drop", 32'(drop_count), 1);
    drain_and_idle("t5");
    // reset with queued data discards it
    b_out_sync = 0;
    for (int v = 20; v <= 23; v++) push(32'(v), 1);
    chk("t6_busy_pre", 32'(busy), 1);
    do_reset();
    chk("t6_b_out", b_out, INIT);
    chk("t6_notify", 32'(b_out_notify), 1);
    chk("t6_drop", 32'(drop_count), 0);
    chk("t6_drop_sat", 32'(drop_count2), 0);
    // five drops: wide counter counts, 2-bit counter saturates
    for (int v = 1; v <= 9; v++) push(32'(v), v <= 4);
    chk("sat_drop", 32'(drop_count), 5);
    chk("sat_drop_sat", 32'(drop_count2), 3);
    drain_and_idle("sat");
    chk("sat_drop_after", 32'(drop_count2), 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
